// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - unsigned W-bit ALU: single-cycle add/sub, W-cycle shift-add mul and restoring div
module multicycle_alu #(
  parameter int W  = 3,
  parameter int CW = $clog2(W+1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_e           state_q;
  logic             in_ready_q, out_valid_q, err_q, is_div_q;
  logic [CW-1:0]    cnt_q;
  logic [2*W-1:0]   result_q, prod_q, mcand_q;
  logic [W-1:0]     mplier_q, rem_q, quo_q, dvsr_q;

  logic [2*W-1:0]   prod_d;
  logic [W-1:0]     rem_d, quo_d;
  logic [W:0]       shifted, trial, add_sum, sub_diff;

  always_comb begin
    prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // Restoring step: bring in the next dividend bit, subtract only if it fits.
    shifted  = {rem_q, quo_q[W-1]};
    trial    = shifted - {1'b0, dvsr_q};
    if (shifted >= {1'b0, dvsr_q}) begin
      rem_d = trial[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_d = shifted[W-1:0];
      quo_d = {quo_q[W-2:0], 1'b0};
    end
    add_sum  = {1'b0, a} + {1'b0, b};
    sub_diff = {1'b0, a} - {1'b0, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            case (op)
              OP_ADD, OP_SUB: begin
                result_q    <= {{(W-1){1'b0}}, (op == OP_ADD) ? add_sum : sub_diff};
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end
              default: begin
                if (op != OP_MUL && b == '0) begin
                  result_q    <= {a, {W{1'b1}}};
                  err_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
                end else begin
                  is_div_q <= (op != OP_MUL);
                  prod_q   <= '0;
                  mcand_q  <= {{W{1'b0}}, a};
                  mplier_q <= b;
                  rem_q    <= '0;
                  quo_q    <= a;
                  dvsr_q   <= b;
                  cnt_q    <= CW'(W);
                  state_q  <= CALC;
                end
              end
            endcase
          end
        end
        CALC: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          rem_q    <= rem_d;
          quo_q    <= quo_d;
          if (cnt_q == CW'(1)) begin
            result_q    <= is_div_q ? {rem_d, quo_d} : prod_d;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed-vector bench for multicycle_alu at W=3
module tb_multicycle_alu;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     op = 2'b00;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           err;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Presents one operation and returns edges from accept edge to out_valid (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_add;
    int lat;
    run_op(2'b00, 3'd5, 3'd6, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    checks++; if (result !== 6'd11) begin errors++; $display("FAIL add_5_6 got %0d want 11", result); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err got %b want 0", err); end
    drain();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL handoff got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_sub;
    int lat;
    run_op(2'b01, 3'd2, 3'd5, lat);
    checks++; if (result !== 6'b001101) begin errors++; $display("FAIL sub_2_5 got %b want 001101", result); end
    drain();
    run_op(2'b01, 3'd5, 3'd5, lat);
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL sub_5_5 got %0d want 0", result); end
    drain();
  endtask

  task automatic test_mul;
    int lat;
    run_op(2'b10, 3'd7, 3'd7, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL mul_latency got %0d want 4", lat); end
    checks++; if (result !== 6'd49) begin errors++; $display("FAIL mul_7_7 got %0d want 49", result); end
    drain();
    run_op(2'b10, 3'd0, 3'd6, lat);
    checks++; if (result !== 6'd0) begin errors++; $display("FAIL mul_0_6 got %0d want 0", result); end
    drain();
    run_op(2'b10, 3'd6, 3'd5, lat);
    checks++; if (result !== 6'd30) begin errors++; $display("FAIL mul_6_5 got %0d want 30", result); end
    drain();
  endtask

  task automatic test_div;
    int lat;
    run_op(2'b11, 3'd5, 3'd0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++; if (result !== {3'd5, 3'd7}) begin errors++; $display("FAIL div_5_0 got %b want 101111", result); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL div0_err got %b want 1", err); end
    drain();
    run_op(2'b11, 3'd7, 3'd2, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL div_latency got %0d want 4", lat); end
    checks++; if (result !== 6'd11) begin errors++; $display("FAIL div_7_2 got %0d want 11", result); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL div_err_clear got %b want 0", err); end
    drain();
    run_op(2'b11, 3'd6, 3'd7, lat);
    checks++; if (result !== {3'd6, 3'd0}) begin errors++; $display("FAIL div_6_7 got %b want 110000", result); end
    drain();
  endtask

  task automatic test_hold;
    int lat;
    run_op(2'b10, 3'd3, 3'd5, lat);
    op = 2'b00; a = 3'd1; b = 3'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 6'd15) begin errors++;
        $display("FAIL hold_%0d got ov=%b ir=%b res=%0d want ov=1 ir=0 res=15", i, out_valid, in_ready, result); end
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL hold_ignored got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_calc;
    int lat;
    op = 2'b10; a = 3'd7; b = 3'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 6'd0 || err !== 1'b0) begin errors++;
      $display("FAIL mid_reset got ov=%b ir=%b res=%0d err=%b want 0 1 0 0", out_valid, in_ready, result, err); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(2'b00, 3'd1, 3'd1, lat);
    checks++; if (lat !== 1 || result !== 6'd2) begin errors++;
      $display("FAIL post_reset_add got lat=%0d res=%0d want lat=1 res=2", lat, result); end
    drain();
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(2'b00, 3'd7, 3'd7, lat);
    drain();
    run_op(2'b01, 3'd6, 3'd1, lat);
    checks++; if (lat !== 1 || result !== 6'd5) begin errors++;
      $display("FAIL b2b_sub got lat=%0d res=%0d want lat=1 res=5", lat, result); end
    drain();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
